// File: rtl/host_slave_mux_cfg_master_if.sv
// Bus between the configuration master and the USB host/slave mux register block.
// 1-bit address, 8-bit data, single-cycle strobed accesses.
interface host_slave_mux_cfg_master_if;
    logic [7:0] busDataIn;
    logic [7:0] busDataOut;
    logic       busAddress;
    logic       busWriteEn;
    logic       busStrobe_o;
    logic       hostSlaveMuxSel;

    modport master (
        input  busDataIn,
        output busDataOut,
        output busAddress,
        output busWriteEn,
        output busStrobe_o,
        output hostSlaveMuxSel
    );

    modport slave (
        output busDataIn,
        input  busDataOut,
        input  busAddress,
        input  busWriteEn,
        input  busStrobe_o,
        input  hostSlaveMuxSel
    );
endinterface

// File: rtl/host_slave_mux_cfg_master.sv
// Configuration master for the USB host/slave mux register block.
// One request runs: read version, optional soft reset + settle wait, write hostMode,
// read hostMode back. Completion and error status go back to the platform control.
module host_slave_mux_cfg_master #(
    parameter logic [7:0]  EXPECTED_VERSION = 8'h22,
    parameter int unsigned RST_WAIT_CYCLES  = 12,
    parameter int unsigned WAIT_CNT_W       = 4
) (
    input  logic                               busClk,
    input  logic                               rst,
    input  logic                               cfgReq,
    input  logic                               cfgHostMode,
    input  logic                               cfgSoftReset,
    host_slave_mux_cfg_master_if.master        bus,
    output logic                               cfgBusy,
    output logic                               cfgAck,
    output logic                               cfgErr,
    output logic [1:0]                         cfgErrCode,
    output logic [7:0]                         versionRb,
    output logic                               hostModeRb
);

    typedef enum logic [2:0] {
        StIdle,
        StRdVer,
        StWrRst,
        StWait,
        StWrHm,
        StRdBack,
        StDone
    } state_e;

    localparam logic [WAIT_CNT_W-1:0] WaitLoad = WAIT_CNT_W'(RST_WAIT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  hm_q, hm_d;
    logic                  sr_q, sr_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic [7:0]            ver_q, ver_d;
    logic                  hmrb_q, hmrb_d;

    logic                  strobe_q, sel_q, we_q, addr_q;
    logic [7:0]            data_q;
    logic                  busy_q, ack_q;

    // Next-state and status capture; busDataIn is consumed at the edge ending each read.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hm_d    = hm_q;
        sr_d    = sr_q;
        err_d   = err_q;
        code_d  = code_q;
        ver_d   = ver_q;
        hmrb_d  = hmrb_q;
        case (state_q)
            StIdle: begin
                if (cfgReq) begin
                    hm_d    = cfgHostMode;
                    sr_d    = cfgSoftReset;
                    err_d   = 1'b0;
                    code_d  = 2'd0;
                    state_d = StRdVer;
                end
            end
            StRdVer: begin
                ver_d = bus.busDataIn;
                if (bus.busDataIn != EXPECTED_VERSION) begin
                    err_d   = 1'b1;
                    code_d  = 2'd1;
                    state_d = StDone;
                end else begin
                    state_d = sr_q ? StWrRst : StWrHm;
                end
            end
            StWrRst: begin
                cnt_d   = WaitLoad;
                state_d = StWait;
            end
            StWait: begin
                // Counter runs RST_WAIT_CYCLES-1 down to 0, one cycle per value.
                if (cnt_q == '0) begin
                    state_d = StWrHm;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            StWrHm: begin
                state_d = StRdBack;
            end
            StRdBack: begin
                hmrb_d = bus.busDataIn[0];
                if (bus.busDataIn[0] != hm_q) begin
                    err_d  = 1'b1;
                    code_d = 2'd2;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register plus Moore outputs decoded from the upcoming state, so they are registered.
    always_ff @(posedge busClk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hm_q     <= 1'b0;
            sr_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
            ver_q    <= 8'h00;
            hmrb_q   <= 1'b0;
            strobe_q <= 1'b0;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 1'b0;
            data_q   <= 8'h00;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hm_q     <= hm_d;
            sr_q     <= sr_d;
            err_q    <= err_d;
            code_q   <= code_d;
            ver_q    <= ver_d;
            hmrb_q   <= hmrb_d;
            strobe_q <= (state_d == StRdVer) || (state_d == StWrRst) ||
                        (state_d == StWrHm)  || (state_d == StRdBack);
            sel_q    <= (state_d == StRdVer) || (state_d == StWrRst) ||
                        (state_d == StWrHm)  || (state_d == StRdBack);
            we_q     <= (state_d == StWrRst) || (state_d == StWrHm);
            addr_q   <= (state_d == StRdVer);
            // Soft reset clears hostMode in the slave, so bit1 and bit0 are never written together.
            if (state_d == StWrRst) begin
                data_q <= 8'h02;
            end else if (state_d == StWrHm) begin
                data_q <= {7'h00, hm_d};
            end else begin
                data_q <= 8'h00;
            end
            busy_q   <= (state_d != StIdle);
            ack_q    <= (state_d == StDone);
        end
    end

    assign bus.busStrobe_o     = strobe_q;
    assign bus.hostSlaveMuxSel = sel_q;
    assign bus.busWriteEn      = we_q;
    assign bus.busAddress      = addr_q;
    assign bus.busDataOut      = data_q;

    assign cfgBusy    = busy_q;
    assign cfgAck     = ack_q;
    assign cfgErr     = err_q;
    assign cfgErrCode = code_q;
    assign versionRb  = ver_q;
    assign hostModeRb = hmrb_q;

endmodule

// File: tb/tb_host_slave_mux_cfg_master.sv
// Scoreboard bench for host_slave_mux_cfg_master: a behavioural slave answers the bus,
// the driver queues expected accesses and completions, a monitor checks them as they appear.
module tb_host_slave_mux_cfg_master;

    localparam int unsigned RstWait = 12;

    typedef struct packed {
        logic       we;
        logic       addr;
        logic [7:0] data;
    } acc_t;

    typedef struct packed {
        logic        err;
        logic [1:0]  code;
        logic [7:0]  ver;
        logic        hmrb;
        logic [31:0] lat;
    } ack_t;

    logic busClk;
    logic rst;
    logic cfgReq, cfgHostMode, cfgSoftReset;
    logic cfgBusy, cfgAck, cfgErr, hostModeRb;
    logic [1:0] cfgErrCode;
    logic [7:0] versionRb;

    host_slave_mux_cfg_master_if bus_if ();

    host_slave_mux_cfg_master #(
        .EXPECTED_VERSION(8'h22),
        .RST_WAIT_CYCLES (RstWait),
        .WAIT_CNT_W      (4)
    ) dut (
        .busClk      (busClk),
        .rst         (rst),
        .cfgReq      (cfgReq),
        .cfgHostMode (cfgHostMode),
        .cfgSoftReset(cfgSoftReset),
        .bus         (bus_if),
        .cfgBusy     (cfgBusy),
        .cfgAck      (cfgAck),
        .cfgErr      (cfgErr),
        .cfgErrCode  (cfgErrCode),
        .versionRb   (versionRb),
        .hostModeRb  (hostModeRb)
    );

    initial busClk = 1'b0;
    always #5 busClk = ~busClk;

    int checks = 0;
    int errors = 0;
    acc_t acc_q[$];
    ack_t ack_q[$];
    logic ref_hmrb = 1'b0;

    // Behavioural slave: version at addr 1, hostMode at addr 0 bit 0, bit1 write = soft reset.
    logic [7:0] slv_ver = 8'h22;
    logic       slv_force = 1'b0;
    logic       slv_hm;

    always_comb begin
        if (bus_if.busAddress) bus_if.busDataIn = slv_ver;
        else                   bus_if.busDataIn = {7'h00, slv_force ? 1'b0 : slv_hm};
    end

    always @(posedge busClk or posedge rst) begin
        if (rst) begin
            slv_hm <= 1'b0;
        end else if (bus_if.busStrobe_o && bus_if.hostSlaveMuxSel && bus_if.busWriteEn &&
                     !bus_if.busAddress) begin
            if (bus_if.busDataOut[1]) slv_hm <= 1'b0;
            else                      slv_hm <= bus_if.busDataOut[0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: sequence of accesses and completion derived from the request alone.
    task automatic push_expect(input logic hm, input logic sr, input logic [7:0] ver,
                               input logic frc);
        logic rb;
        logic e;
        acc_q.push_back(acc_t'{we: 1'b0, addr: 1'b1, data: 8'h00});
        if (ver != 8'h22) begin
            ack_q.push_back(ack_t'{err: 1'b1, code: 2'd1, ver: ver, hmrb: ref_hmrb, lat: 32'd2});
        end else begin
            if (sr) acc_q.push_back(acc_t'{we: 1'b1, addr: 1'b0, data: 8'h02});
            acc_q.push_back(acc_t'{we: 1'b1, addr: 1'b0, data: {7'h00, hm}});
            acc_q.push_back(acc_t'{we: 1'b0, addr: 1'b0, data: 8'h00});
            rb = frc ? 1'b0 : hm;
            e  = (rb != hm);
            ref_hmrb = rb;
            ack_q.push_back(ack_t'{err: e, code: e ? 2'd2 : 2'd0, ver: ver, hmrb: rb,
                                   lat: sr ? 32'(RstWait + 5) : 32'd4});
        end
    endtask

    // Monitor: compares every strobe and every cfgAck against the scoreboard.
    int   cyc = 0;
    int   start_cyc = 0;
    logic busy_prev = 1'b0;

    always @(negedge busClk) begin
        acc_t a;
        ack_t k;
        cyc++;
        if (rst) begin
            busy_prev = 1'b0;
        end else begin
            if (cfgBusy && !busy_prev) start_cyc = cyc;
            busy_prev = cfgBusy;
            if (bus_if.busStrobe_o || bus_if.hostSlaveMuxSel)
                chk("sel_with_strobe", 32'(bus_if.hostSlaveMuxSel), 32'(bus_if.busStrobe_o));
            if (bus_if.busStrobe_o) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    a = acc_q.pop_front();
                    chk("acc_we", 32'(bus_if.busWriteEn), 32'(a.we));
                    chk("acc_addr", 32'(bus_if.busAddress), 32'(a.addr));
                    chk("acc_data", 32'(bus_if.busDataOut), 32'(a.data));
                end
            end
            if (cfgAck) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    k = ack_q.pop_front();
                    chk("ack_err", 32'(cfgErr), 32'(k.err));
                    chk("ack_code", 32'(cfgErrCode), 32'(k.code));
                    chk("ack_version", 32'(versionRb), 32'(k.ver));
                    chk("ack_hmrb", 32'(hostModeRb), 32'(k.hmrb));
                    chk("ack_latency", 32'(cyc - start_cyc + 1), k.lat);
                    chk("ack_busy", 32'(cfgBusy), 32'd1);
                end
            end
        end
    end

    task automatic start_req(input logic hm, input logic sr, input logic [7:0] ver,
                             input logic frc);
        slv_ver   = ver;
        slv_force = frc;
        push_expect(hm, sr, ver, frc);
        @(negedge busClk);
        cfgHostMode  = hm;
        cfgSoftReset = sr;
        cfgReq       = 1'b1;
        @(negedge busClk);
        cfgReq = 1'b0;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!cfgAck && n < 100) begin
            @(negedge busClk);
            n++;
        end
        if (!cfgAck) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_req(input logic hm, input logic sr, input logic [7:0] ver,
                           input logic frc);
        logic exp_err;
        start_req(hm, sr, ver, frc);
        wait_ack();
        exp_err = cfgErr;
        @(negedge busClk);
        chk("err_held_idle", 32'(cfgErr), 32'(exp_err));
        chk("busy_idle", 32'(cfgBusy), 32'd0);
    endtask

    initial begin
        int n;
        int extra;
        logic [7:0] v;
        rst          = 1'b1;
        cfgReq       = 1'b0;
        cfgHostMode  = 1'b0;
        cfgSoftReset = 1'b0;
        repeat (3) @(negedge busClk);
        chk("rst_strobe", 32'(bus_if.busStrobe_o), 32'd0);
        chk("rst_sel", 32'(bus_if.hostSlaveMuxSel), 32'd0);
        chk("rst_data", 32'(bus_if.busDataOut), 32'd0);
        chk("rst_status", 32'({cfgBusy, cfgAck, cfgErr, cfgErrCode, versionRb, hostModeRb}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge busClk);

        run_req(1'b1, 1'b0, 8'h22, 1'b0);
        run_req(1'b1, 1'b1, 8'h22, 1'b0);
        chk("slave_hm_after_srst", 32'(slv_hm), 32'd1);
        run_req(1'b0, 1'b0, 8'h11, 1'b0);
        run_req(1'b1, 1'b0, 8'h22, 1'b1);

        // Reset during the settle wait aborts the sequence.
        start_req(1'b1, 1'b1, 8'h22, 1'b0);
        n = 0;
        while (!(bus_if.busStrobe_o && bus_if.busWriteEn && bus_if.busDataOut == 8'h02) &&
               n < 20) begin
            @(negedge busClk);
            n++;
        end
        chk("saw_srst_write", 32'(bus_if.busDataOut), 32'h02);
        repeat (4) @(negedge busClk);
        #2 rst = 1'b1;
        #1;
        chk("abort_bus", 32'({bus_if.busStrobe_o, bus_if.hostSlaveMuxSel, bus_if.busWriteEn,
                              bus_if.busAddress, bus_if.busDataOut}), 32'd0);
        chk("abort_status", 32'({cfgBusy, cfgAck, cfgErr, cfgErrCode, versionRb, hostModeRb}),
            32'd0);
        acc_q.delete();
        ack_q.delete();
        ref_hmrb = 1'b0;
        repeat (3) @(negedge busClk);
        rst = 1'b0;
        run_req(1'b1, 1'b1, 8'h22, 1'b0);

        // cfgReq pulsed during the readback must be ignored.
        start_req(1'b1, 1'b0, 8'h22, 1'b0);
        n = 0;
        while (!(bus_if.busStrobe_o && !bus_if.busWriteEn && !bus_if.busAddress) && n < 20) begin
            @(negedge busClk);
            n++;
        end
        cfgReq      = 1'b1;
        cfgHostMode = 1'b0;
        @(negedge busClk);
        cfgReq = 1'b0;
        wait_ack();
        extra = 0;
        repeat (10) begin
            @(negedge busClk);
            if (cfgBusy || cfgAck) extra++;
        end
        chk("ignored_req", 32'(extra), 32'd0);

        // cfgReq held high: back-to-back sequences with a one-cycle idle gap.
        slv_ver   = 8'h22;
        slv_force = 1'b0;
        push_expect(1'b0, 1'b0, 8'h22, 1'b0);
        push_expect(1'b0, 1'b0, 8'h22, 1'b0);
        @(negedge busClk);
        cfgHostMode  = 1'b0;
        cfgSoftReset = 1'b0;
        cfgReq       = 1'b1;
        @(negedge busClk);
        wait_ack();
        @(negedge busClk);
        chk("gap_busy_low", 32'(cfgBusy), 32'd0);
        @(negedge busClk);
        chk("gap_reaccept", 32'(cfgBusy), 32'd1);
        cfgReq = 1'b0;
        wait_ack();
        @(negedge busClk);

        for (int i = 0; i < 24; i++) begin
            v = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h22;
            if (v == 8'h22 && i % 7 == 3) v = 8'h23;
            run_req(1'($urandom), 1'($urandom), v, ($urandom_range(4) == 0));
        end

        repeat (3) @(negedge busClk);
        chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
        chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
